// File: rtl/top_sdiv_pkg.sv
// Shared widths, saturation limits and FSM encoding for the sequential signed divider.
package top_sdiv_pkg;

    localparam int DIVIDEND_W = 25;
    localparam int DIVISOR_W  = 8;
    localparam int QUOT_W     = 16;
    localparam int REM_W      = DIVISOR_W + 1;

    localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/top_sdiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract the divisor.
module top_sdiv_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 din_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 qbit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] divisor_ext;

    always_comb begin
        // rem_in is always below the divisor, so the shifted value stays under 2*divisor
        shifted     = {rem_in, din_bit};
        divisor_ext = {2'b00, divisor};
        qbit        = (shifted >= divisor_ext);
        rem_out     = (DIVISOR_W+1)'(qbit ? (shifted - divisor_ext) : shifted);
    end

endmodule

// File: rtl/top_sdiv_25s_8ns_16_seq.sv
// Sequential restoring divider: 25-bit signed / 8-bit unsigned -> saturating 16-bit quotient, 9-bit remainder.
// Optional TOP_SDIV_FAST_ZERO_EN: zero divisor or zero dividend completes with latency 1.
module top_sdiv_25s_8ns_16_seq #(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = top_sdiv_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = top_sdiv_pkg::DIVISOR_W,
    parameter int QUOT_W     = top_sdiv_pkg::QUOT_W,
    parameter int REM_W      = DIVISOR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [QUOT_W-1:0]     dout_q,
    output logic [REM_W-1:0]      dout_r,
    output logic                  ovf,
    output logic                  dz,
    output logic                  out_valid,
    input  logic                  out_ready
);

    import top_sdiv_pkg::*;

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(1) << (QUOT_W - 1);
    localparam logic [DIVIDEND_W-1:0] POS_LIM = NEG_LIM - DIVIDEND_W'(1);
    localparam logic [CNT_W-1:0]      CNT_TOP = CNT_W'(DIVIDEND_W - 1);

    state_t state_reg, state_next;

    logic [DIVIDEND_W-1:0] mag_reg;
    logic                  neg_reg;
    logic [DIVISOR_W-1:0]  div_reg;
    logic [REM_W-1:0]      rem_reg;
    logic [DIVIDEND_W-1:0] qmag_reg;
    logic [CNT_W-1:0]      cnt_reg;

    logic [QUOT_W-1:0]     dout_q_reg, dout_q_next;
    logic [REM_W-1:0]      dout_r_reg, dout_r_next;
    logic                  ovf_reg, ovf_next;
    logic                  dz_reg, dz_next;

    logic                  load;
    logic                  step_en;
    logic                  last_step;
    logic                  fast_zero;
    logic [DIVIDEND_W-1:0] din0_mag;
    logic [REM_W-1:0]      step_rem;
    logic                  step_qbit;
    logic [DIVIDEND_W-1:0] qmag_final;

`ifdef TOP_SDIV_FAST_ZERO_EN
    assign fast_zero = (din1 == '0) || (din0 == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // Two's-complement negate of the most negative dividend yields 2^(W-1), which is the exact magnitude.
    assign din0_mag  = din0[DIVIDEND_W-1] ? (~din0 + DIVIDEND_W'(1)) : din0;
    assign last_step = (cnt_reg == '0);

    top_sdiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_reg),
        .din_bit (mag_reg[cnt_reg]),
        .divisor (div_reg),
        .rem_out (step_rem),
        .qbit    (step_qbit)
    );

    assign qmag_final = {qmag_reg[DIVIDEND_W-2:0], step_qbit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (ce) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step_en    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result formation from the final step, with sign restore and saturation.
    always_comb begin
        dout_q_next = '0;
        dout_r_next = '0;
        ovf_next    = 1'b0;
        dz_next     = 1'b0;
        if (div_reg == '0) begin
            dz_next     = 1'b1;
            dout_q_next = neg_reg ? QUOT_W'(Q_MIN) : QUOT_W'(Q_MAX);
        end else begin
            dout_r_next = neg_reg ? (~step_rem + REM_W'(1)) : step_rem;
            if (neg_reg) begin
                if (qmag_final <= NEG_LIM) begin
                    dout_q_next = ~qmag_final[QUOT_W-1:0] + QUOT_W'(1);
                end else begin
                    dout_q_next = QUOT_W'(Q_MIN);
                    ovf_next    = 1'b1;
                end
            end else begin
                if (qmag_final <= POS_LIM) begin
                    dout_q_next = qmag_final[QUOT_W-1:0];
                end else begin
                    dout_q_next = QUOT_W'(Q_MAX);
                    ovf_next    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mag_reg    <= '0;
            neg_reg    <= 1'b0;
            div_reg    <= '0;
            rem_reg    <= '0;
            qmag_reg   <= '0;
            cnt_reg    <= '0;
            dout_q_reg <= '0;
            dout_r_reg <= '0;
            ovf_reg    <= 1'b0;
            dz_reg     <= 1'b0;
        end else if (ce) begin
            if (load) begin
                mag_reg  <= din0_mag;
                neg_reg  <= din0[DIVIDEND_W-1];
                div_reg  <= din1;
                rem_reg  <= '0;
                qmag_reg <= '0;
                // Fast-zero operations take a single pass through CALC, giving latency 1.
                cnt_reg  <= fast_zero ? '0 : CNT_TOP;
            end else if (step_en) begin
                rem_reg  <= step_rem;
                qmag_reg <= qmag_final;
                cnt_reg  <= cnt_reg - CNT_W'(1);
                if (last_step) begin
                    dout_q_reg <= dout_q_next;
                    dout_r_reg <= dout_r_next;
                    ovf_reg    <= ovf_next;
                    dz_reg     <= dz_next;
                end
            end
        end
    end

    assign dout_q = dout_q_reg;
    assign dout_r = dout_r_reg;
    assign ovf    = ovf_reg;
    assign dz     = dz_reg;

endmodule

// File: tb/tb_top_sdiv_25s_8ns_16_seq.sv
// Randomized and directed bench for the sequential signed divider against a plain-arithmetic reference.
module tb_top_sdiv_25s_8ns_16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [24:0] din0;
    logic [7:0]  din1;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dout_q;
    logic [8:0]  dout_r;
    logic        ovf;
    logic        dz;
    logic        out_valid;
    logic        out_ready;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    top_sdiv_25s_8ns_16_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .din0      (din0),
        .din1      (din1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout_q    (dout_q),
        .dout_r    (dout_r),
        .ovf       (ovf),
        .dz        (dz),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int a, input int d, output int q, output int r,
                                  output int ov, output int z);
        ov = 0;
        if (d == 0) begin
            z = 1;
            r = 0;
            q = (a < 0) ? -32768 : 32767;
        end else begin
            z = 0;
            q = a / d;
            r = a % d;
            if (q > 32767) begin
                q  = 32767;
                ov = 1;
            end else if (q < -32768) begin
                q  = -32768;
                ov = 1;
            end
        end
    endfunction

    function automatic int exp_latency(input int a, input int d);
`ifdef TOP_SDIV_FAST_ZERO_EN
        if (a == 0 || d == 0) return 1;
`endif
        return 25;
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        din0     = 25'($urandom);
        din1     = 8'($urandom);
    endtask

    // One full transaction: accept, optional ce gap, optional DONE hold, release.
    task automatic do_op(input int a, input int d, input int gap_at, input int gap_len, input int hold);
        int q, r, ov, z, lat, edges, en_edges;
        logic [24:0] a_bits;
        model(a, d, q, r, ov, z);
        lat    = exp_latency(a, d);
        a_bits = 25'(a);
        @(negedge clk);
        ce        = 1'b1;
        out_ready = 1'b0;
        din0      = a_bits;
        din1      = 8'(d);
        in_valid  = 1'b1;
        check("in_ready_idle", longint'(in_ready), 1);
        @(posedge clk);
        edges    = 0;
        en_edges = 0;
        @(negedge clk);
        scramble_inputs();
        while (!out_valid && edges < 100) begin
            check("in_ready_busy", longint'(in_ready), 0);
            ce = !(edges >= gap_at && edges < gap_at + gap_len);
            @(posedge clk);
            edges++;
            if (ce) en_edges++;
            @(negedge clk);
            scramble_inputs();
        end
        ce = 1'b1;
        check("out_valid_timeout", longint'(out_valid), 1);
        check("latency_enabled", en_edges, lat);
        check("latency_raw", edges, lat + ((gap_at < lat) ? gap_len : 0));
        check("dout_q", longint'($signed(dout_q)), q);
        check("dout_r", longint'($signed(dout_r)), r);
        check("ovf", longint'(ovf), ov);
        check("dz", longint'(dz), z);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                ce        = 1'b0;
                out_ready = 1'b1;
            end else begin
                ce        = 1'b1;
                out_ready = 1'b0;
            end
            in_valid = 1'b1;
            din0     = 25'($urandom);
            din1     = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", longint'(out_valid), 1);
            check("hold_in_ready", longint'(in_ready), 0);
            check("hold_q", longint'($signed(dout_q)), q);
            check("hold_r", longint'($signed(dout_r)), r);
        end
        ce        = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", longint'(out_valid), 0);
        check("release_in_ready", longint'(in_ready), 1);
        check("release_q_kept", longint'($signed(dout_q)), q);
        $display("[TB] op a=%0d d=%0d q=%0d r=%0d ovf=%0d dz=%0d lat=%0d",
                 a, d, $signed(dout_q), $signed(dout_r), ovf, dz, en_edges);
    endtask

    initial begin
        int a, d;
        logic [24:0] t;
        reset     = 1'b1;
        ce        = 1'b0;
        din0      = '0;
        din1      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_q", longint'(dout_q), 0);
        check("rst_r", longint'(dout_r), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_dz", longint'(dz), 0);
        reset = 1'b0;
        ce    = 1'b1;

        do_op(-200000, 200, 100, 0, 0);
        do_op(12345, 7, 100, 0, 0);
        do_op(-12345, 7, 100, 0, 0);
        do_op(8388607, 1, 100, 0, 0);
        do_op(-8388608, 1, 100, 0, 0);
        do_op(-16777216, 1, 100, 0, 0);
        do_op(-16777216, 255, 100, 0, 0);
        do_op(-32768, 1, 100, 0, 0);
        do_op(32767, 1, 100, 0, 0);
        do_op(-5, 0, 100, 0, 0);
        do_op(77, 0, 100, 0, 0);
        do_op(0, 13, 100, 0, 0);
        do_op(12345, 7, 5, 3, 5);

        // Reset in the middle of CALC, with ce low to show reset ignores it.
        @(negedge clk);
        ce       = 1'b1;
        din0     = 25'(1000000);
        din1     = 8'(3);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ce    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        check("midrst_q", longint'(dout_q), 0);
        check("midrst_r", longint'(dout_r), 0);
        check("midrst_ovf", longint'(ovf), 0);
        check("midrst_dz", longint'(dz), 0);
        reset = 1'b0;
        ce    = 1'b1;
        do_op(-1234, 10, 100, 0, 2);

        for (int n = 0; n < 24; n++) begin
            t = 25'($urandom);
            case ($urandom_range(0, 3))
                0: a = int'($signed(t));
                1: a = $urandom_range(0, 200000) - 100000;
                2: a = $urandom_range(0, 1) ? 0 : int'($signed(t));
                default: a = $urandom_range(0, 16000000) - 8000000;
            endcase
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            do_op(a, d, $urandom_range(0, 30), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/top_sdiv_25s_8ns_16_seq.md
Name: top_sdiv_25s_8ns_16_seq

Overview:
- Sequential restoring divider; the inverse of the 16s x 8ns -> 25 pipelined multiply in the normalRNG datapath.
- Takes a 25-bit signed dividend and an 8-bit unsigned divisor.
- Returns a 16-bit signed quotient (truncated toward zero, saturating) and a 9-bit signed remainder.
- Used to rescale products back into the 16-bit sample domain. One quotient bit per enabled cycle; valid/ready handshakes on both sides.

Parameters:
- ID, 1, instance tag; no functional effect.
- DIVIDEND_W, 25, dividend width (signed).
- DIVISOR_W, 8, divisor width (unsigned).
- QUOT_W, 16, quotient output width (signed, saturating).
- REM_W, DIVISOR_W+1, remainder width (signed).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state and outputs hold and no handshake completes.
- din0  in  DIVIDEND_W  signed dividend.
- din1  in  DIVISOR_W  unsigned divisor.
- in_valid  in  1  din0/din1 valid.
- in_ready  out  1  block can accept; high only in IDLE.
- dout_q  out  QUOT_W  signed quotient.
- dout_r  out  REM_W  signed remainder.
- ovf  out  1  quotient saturated (magnitude out of range).
- dz  out  1  divisor was zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (reset=1 at an edge, regardless of ce):
  - state goes to IDLE.
  - out_valid, dout_q, dout_r, ovf, dz all go to 0.
  - in_ready is 1 after the edge.
  - Reset mid-CALC or in DONE discards the operation; no partial result is ever presented.
- FSM states: IDLE, CALC, DONE. Transitions happen only on edges with ce=1.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture |din0| as a 25-bit magnitude, plus sign(din0) and din1.
  - Clear the partial remainder; set bit counter=DIVIDEND_W-1; go to CALC.
- CALC, one restoring step per enabled edge:
  - rem = {rem[7:0], mag[cnt]}.
  - If rem >= divisor: rem -= divisor and qbit=1; else qbit=0.
  - Quotient magnitude shifts left by one and takes qbit.
  - When cnt==0, go to DONE and register the results the same edge.
- Latency: out_valid rises 25 enabled edges after the accepting edge. The ce-low cycles in between extend the latency 1:1.
- Result formation, on the CALC->DONE edge:
  - Quotient sign = sign(dividend); remainder sign = sign(dividend). This is C truncation semantics: q*d+r == dividend when there is no saturation.
  - Negative result with magnitude <= 32768: dout_q = -magnitude, ovf=0.
  - Positive result with magnitude <= 32767: dout_q = magnitude, ovf=0.
  - Otherwise: dout_q=32767 (positive) or -32768 (negative), ovf=1. dout_r stays the true remainder.
  - Remainder magnitude is always <= 254; its sign follows the dividend, with zero remainder reported as 0.
- Divide by zero (captured din1==0):
  - CALC still runs the full 25 cycles.
  - Result is forced: dz=1, ovf=0, dout_r=0.
  - dout_q=32767 if dividend>=0, else -32768.
- DONE:
  - out_valid=1; outputs stay stable until out_valid && out_ready with ce=1.
  - That edge returns to IDLE, clears out_valid, and leaves the data outputs unchanged.
  - in_ready=0 in DONE, so there is no same-cycle accept on the releasing edge. Minimum initiation interval is 27 enabled cycles.
- in_valid in CALC or DONE is ignored; the input is not captured.
- din0=-2^24 (most negative) has magnitude 2^24 and must be handled exactly.

Optional Feature:
- Macro: TOP_SDIV_FAST_ZERO_EN.
- Defined:
  - On acceptance, if din1==0 or din0==0, skip CALC and go straight to DONE.
  - out_valid appears on the next enabled edge (latency 1) with the forced or zero result.
  - din0==0 with din1!=0 gives q=0, r=0, dz=0, ovf=0.
- Undefined: every operation takes the full 25-cycle latency, so latency is data-independent.

Decomposition:
- Package top_sdiv_pkg holds:
  - width constants (DIVIDEND_W, DIVISOR_W, QUOT_W, REM_W);
  - the Q_MAX=32767 and Q_MIN=-32768 constants;
  - the state enum typedef {IDLE, CALC, DONE}.
- Sub-module top_sdiv_step: combinational single restoring step.
  - Inputs: rem_in[8:0], next dividend bit, divisor.
  - Outputs: rem_out, qbit.
  - Instantiated once by the FSM-owning top.

Test Plan:
- reset mid-CALC after 10 cycles, then a new op: outputs 0 and in_ready=1 after the edge; the new op completes with correct values and no stale result.
- din0=-200000, din1=200 -> dout_q=-1000, dout_r=0, ovf=0, dz=0, out_valid exactly 25 edges after accept; din0=12345, din1=7 -> q=1763, r=4; din0=-12345, din1=7 -> q=-1763, r=-4.
- din0=8388607, din1=1 -> q=32767, ovf=1, r=0; din0=-8388608, din1=1 -> q=-32768, ovf=1; din0=-32768, din1=1 -> q=-32768, ovf=0.
- din1=0, din0=-5 -> dz=1, q=-32768, r=0. Latency is 25 without TOP_SDIV_FAST_ZERO_EN and 1 with it.
- ce low for 3 cycles mid-CALC -> latency becomes 28 and the result is unchanged. In DONE with out_ready=0 for 5 cycles: outputs stable, in_ready=0, in_valid ignored. Release with out_ready=1 -> IDLE next edge.
